// File: rtl/mux_pkg.sv
// Shared types and limits for the round-robin stream multiplexer.
package mux_pkg;

    // Arbitration mode: fixed channel select or rotating priority.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    // Output buffer occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Largest supported channel count.
    localparam int MAX_CH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed-select or round-robin grant over NUM_CH requests.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] Req,
    input  logic [SEL_W-1:0]  Last,
    input  logic              Mode,
    input  logic [SEL_W-1:0]  Sel,
    output logic              GrantValid,
    output logic [SEL_W-1:0]  GrantIdx
);

    logic [SEL_W-1:0] w_cand;

    // Pick the granted channel; the RR scan runs farthest-first so the nearest
    // requester after Last is the one left standing.
    always_comb begin
        GrantValid = 1'b0;
        GrantIdx   = '0;
        w_cand     = '0;
        if (mux_mode_t'(Mode) == MODE_RR) begin
            for (int k = NUM_CH; k >= 1; k--) begin
                w_cand = SEL_W'((int'(Last) + k) % NUM_CH);
                if (Req[w_cand]) begin
                    GrantValid = 1'b1;
                    GrantIdx   = w_cand;
                end
            end
        end else begin
            // Select values past the last channel never grant.
            if ((int'(Sel) < NUM_CH) && Req[Sel]) begin
                GrantValid = 1'b1;
                GrantIdx   = Sel;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with fixed or round-robin arbitration and a
// single registered output slot that can drain and reload in the same cycle.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_CH*DATA_W-1:0] InData,
    input  logic [NUM_CH-1:0]        InValid,
    output logic [NUM_CH-1:0]        InReady,
    input  logic                     Mode,
    input  logic [SEL_W-1:0]         Sel,
    output logic [DATA_W-1:0]        ValOut,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [SEL_W-1:0]         OutSel
);

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_last;
    logic              w_ld_en;
    logic              w_xfer;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [DATA_W-1:0] w_ch [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_ch[i] = InData[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .Req       (InValid),
        .Last      (r_last),
        .Mode      (Mode),
        .Sel       (Sel),
        .GrantValid(w_gnt_vld),
        .GrantIdx  (w_gnt_idx)
    );

    // The slot can take a new item whenever it is empty or being drained.
    assign OutValid = (r_state == ST_FULL);
    assign w_ld_en  = !OutValid || OutReady;
    assign w_xfer   = w_ld_en && w_gnt_vld;
    assign ValOut   = r_data;
    assign OutSel   = r_sel;

    // One-hot accept toward the granted producer, only when the slot can load.
    always_comb begin
        InReady = '0;
        if (w_xfer) begin
            InReady[w_gnt_idx] = 1'b1;
        end
    end

    // Next buffer state: load wins, otherwise a drain empties the slot.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if (w_ld_en) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Buffer state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted item and remember its channel as the RR reference;
    // Last resets to the top channel so channel 0 wins first.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_last <= SEL_W'(NUM_CH - 1);
        end else if (w_xfer) begin
            r_data <= w_ch[w_gnt_idx];
            r_sel  <= w_gnt_idx;
            r_last <= w_gnt_idx;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: 4-channel instance against a
// behavioural model, plus a 3-channel instance for the out-of-range select.
module tb_rr_stream_mux;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    logic [31:0] InData   = '0;
    logic [3:0]  InValid  = '0;
    logic [3:0]  InReady;
    logic        Mode     = 1'b0;
    logic [1:0]  Sel      = '0;
    logic [7:0]  ValOut;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [1:0]  OutSel;

    logic [23:0] InData3   = '0;
    logic [2:0]  InValid3  = '0;
    logic [2:0]  InReady3;
    logic        Mode3     = 1'b0;
    logic [1:0]  Sel3      = '0;
    logic [7:0]  ValOut3;
    logic        OutValid3;
    logic        OutReady3 = 1'b1;
    logic [1:0]  OutSel3;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the 4-channel instance
    bit         m_vld  = 1'b0;
    logic [7:0] m_data = '0;
    int         m_sel  = 0;
    int         m_last = 3;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 Clk = ~Clk;

    rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut4 (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid),
        .InReady(InReady), .Mode(Mode), .Sel(Sel), .ValOut(ValOut),
        .OutValid(OutValid), .OutReady(OutReady), .OutSel(OutSel)
    );

    rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .Clk(Clk), .Rst(Rst), .InData(InData3), .InValid(InValid3),
        .InReady(InReady3), .Mode(Mode3), .Sel(Sel3), .ValOut(ValOut3),
        .OutValid(OutValid3), .OutReady(OutReady3), .OutSel(OutSel3)
    );

    function automatic int mgrant(bit mode, int sel, logic [3:0] v, int last, int n);
        int c;
        if (!mode) return (sel < n && v[sel]) ? sel : -1;
        for (int k = 1; k <= n; k++) begin
            c = (last + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] mready();
        bit ld;
        int g;
        ld = !m_vld || OutReady;
        g  = mgrant(Mode, int'(Sel), InValid, m_last, 4);
        if (ld && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    // Advance one clock, updating the model and the output scoreboard.
    task automatic tick();
        bit ld;
        int g;
        ld = !m_vld || OutReady;
        g  = mgrant(Mode, int'(Sel), InValid, m_last, 4);
        if (OutValid && OutReady) rx_q.push_back(ValOut);
        @(posedge Clk);
        if (ld && g >= 0) begin
            m_vld  = 1'b1;
            m_data = InData[g*8 +: 8];
            m_sel  = g;
            m_last = g;
            tx_q.push_back(m_data);
        end else if (ld) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_data = '0;
        m_sel  = 0;
        m_last = 3;
        tx_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
        checks++;
        if (ValOut !== 8'h00) begin errors++; $display("FAIL reset_valout: got %h expected 00", ValOut); end
        checks++;
        if (OutSel !== 2'd0) begin errors++; $display("FAIL reset_outsel: got %0d expected 0", OutSel); end
        checks++;
        if (OutValid3 !== 1'b0) begin errors++; $display("FAIL reset_outvalid3: got %b expected 0", OutValid3); end
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fixed();
        InData   = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
        InValid  = 4'b1111;
        OutReady = 1'b1;
        Mode     = 1'b0;
        for (int s = 0; s < 4; s++) begin
            Sel = 2'(s);
            #1;
            checks++;
            if (InReady !== mready()) begin errors++; $display("FAIL fixed_inready: got %b expected %b", InReady, mready()); end
            tick();
            checks++;
            if (ValOut !== 8'(8'h0a + s) || ValOut !== m_data) begin
                errors++; $display("FAIL fixed_valout sel=%0d: got %h expected %h", s, ValOut, 8'(8'h0a + s));
            end
            checks++;
            if (OutSel !== 2'(s) || OutValid !== 1'b1) begin
                errors++; $display("FAIL fixed_outsel: got sel %0d vld %b expected sel %0d vld 1", OutSel, OutValid, s);
            end
        end
    endtask

    task automatic test_rr_all();
        Mode    = 1'b1;
        InValid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (InReady !== mready()) begin errors++; $display("FAIL rr_all_inready: got %b expected %b", InReady, mready()); end
            tick();
            checks++;
            if (OutSel !== 2'(k % 4) || OutValid !== 1'b1) begin
                errors++; $display("FAIL rr_all_order cycle %0d: got sel %0d vld %b expected sel %0d vld 1", k, OutSel, OutValid, k % 4);
            end
            checks++;
            if (ValOut !== m_data) begin errors++; $display("FAIL rr_all_data: got %h expected %h", ValOut, m_data); end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_seq[4] = '{1, 3, 1, 3};
        Mode    = 1'b1;
        InValid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (InReady[0] !== 1'b0 || InReady[2] !== 1'b0 || InReady !== mready()) begin
                errors++; $display("FAIL rr_sparse_inready: got %b expected %b", InReady, mready());
            end
            tick();
            checks++;
            if (OutSel !== 2'(exp_seq[k])) begin
                errors++; $display("FAIL rr_sparse_order cycle %0d: got %0d expected %0d", k, OutSel, exp_seq[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        InValid  = 4'b0000;
        OutReady = 1'b1;
        tick();
        tx_q.delete();
        rx_q.delete();
        Mode    = 1'b0;
        Sel     = 2'd1;
        InData  = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
        InValid = 4'b0010;
        tick();
        checks++;
        if (ValOut !== 8'h0b || OutValid !== 1'b1) begin
            errors++; $display("FAIL bp_load: got %h vld %b expected 0b vld 1", ValOut, OutValid);
        end
        OutReady = 1'b0;
        InData   = {8'h0d, 8'h0c, 8'h5b, 8'h0a};
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (InReady !== 4'b0000) begin errors++; $display("FAIL bp_inready: got %b expected 0000", InReady); end
            tick();
            checks++;
            if (ValOut !== 8'h0b || OutSel !== 2'd1 || OutValid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %h sel %0d vld %b expected 0b sel 1 vld 1", k, ValOut, OutSel, OutValid);
            end
        end
        OutReady = 1'b1;
        #1;
        checks++;
        if (InReady !== 4'b0010) begin errors++; $display("FAIL bp_release_inready: got %b expected 0010", InReady); end
        tick();
        checks++;
        if (ValOut !== 8'h5b || OutValid !== 1'b1) begin
            errors++; $display("FAIL bp_release_data: got %h vld %b expected 5b vld 1", ValOut, OutValid);
        end
        InValid = 4'b0000;
        tick();
        checks++;
        if (OutValid !== 1'b0 || ValOut !== 8'h5b) begin
            errors++; $display("FAIL bp_drain: got vld %b data %h expected vld 0 data 5b", OutValid, ValOut);
        end
        checks++;
        if (rx_q.size() != 2 || tx_q.size() != 2 || rx_q != tx_q) begin
            errors++; $display("FAIL bp_scoreboard: got %0d items out expected %0d", rx_q.size(), tx_q.size());
        end
    endtask

    task automatic test_nch3();
        InValid   = 4'b0000;
        Mode3     = 1'b0;
        Sel3      = 2'd3;
        InData3   = {8'h33, 8'h22, 8'h11};
        InValid3  = 3'b111;
        OutReady3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (InReady3 !== 3'b000) begin errors++; $display("FAIL nch3_sel3_inready: got %b expected 000", InReady3); end
            tick();
            checks++;
            if (OutValid3 !== 1'b0) begin errors++; $display("FAIL nch3_sel3_outvalid: got %b expected 0", OutValid3); end
        end
        Sel3 = 2'd2;
        #1;
        checks++;
        if (InReady3 !== 3'b100) begin errors++; $display("FAIL nch3_sel2_inready: got %b expected 100", InReady3); end
        tick();
        checks++;
        if (OutValid3 !== 1'b1 || ValOut3 !== 8'h33 || OutSel3 !== 2'd2) begin
            errors++; $display("FAIL nch3_sel2_out: got vld %b data %h sel %0d expected vld 1 data 33 sel 2", OutValid3, ValOut3, OutSel3);
        end
        InValid3 = 3'b000;
    endtask

    task automatic test_random();
        int bad = 0;
        InValid  = 4'b0000;
        OutReady = 1'b1;
        tick();
        tx_q.delete();
        rx_q.delete();
        for (int k = 0; k < 300; k++) begin
            Mode     = 1'($urandom_range(0, 1));
            Sel      = 2'($urandom_range(0, 3));
            InValid  = 4'($urandom);
            InData   = $urandom;
            OutReady = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (InReady !== mready()) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_inready cycle %0d: got %b expected %b", k, InReady, mready());
            end
            tick();
            checks++;
            if (OutValid !== m_vld || ValOut !== m_data || OutSel !== 2'(m_sel)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_out cycle %0d: got vld %b data %h sel %0d expected vld %b data %h sel %0d",
                                       k, OutValid, ValOut, OutSel, m_vld, m_data, m_sel);
            end
        end
        InValid  = 4'b0000;
        OutReady = 1'b1;
        tick();
        checks++;
        if (rx_q.size() != tx_q.size() || rx_q != tx_q) begin
            errors++; $display("FAIL rand_scoreboard: got %0d items out expected %0d", rx_q.size(), tx_q.size());
        end
    endtask

    task automatic test_async_reset();
        Mode     = 1'b1;
        InData   = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
        InValid  = 4'b1111;
        OutReady = 1'b1;
        tick();
        tick();
        checks++;
        if (OutValid !== 1'b1) begin errors++; $display("FAIL arst_prefull: got %b expected 1", OutValid); end
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if (OutValid !== 1'b0 || ValOut !== 8'h00 || OutSel !== 2'd0) begin
            errors++; $display("FAIL arst_immediate: got vld %b data %h sel %0d expected vld 0 data 00 sel 0", OutValid, ValOut, OutSel);
        end
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (InReady !== 4'b0001) begin errors++; $display("FAIL arst_first_inready: got %b expected 0001", InReady); end
        tick();
        checks++;
        if (OutSel !== 2'd0 || ValOut !== 8'h0a || OutValid !== 1'b1) begin
            errors++; $display("FAIL arst_first_grant: got sel %0d data %h vld %b expected sel 0 data 0a vld 1", OutSel, ValOut, OutValid);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_nch3();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
